// File: rtl/mode_selector_pkg.sv
// Shared definitions for the mode selector and the per-mode reset stage that
// consumes its mode word.
//   MODE_*              : 2-bit mode encodings (HOME is the idle mode)
//   DEBOUNCE_CYCLES_DEF : default debounce hold time (10 ms at 100 MHz)
//   mode_advance()      : successor of a mode on a "next" press
package mode_pkg;

  localparam logic [1:0] MODE_HOME = 2'b00;
  localparam logic [1:0] MODE_1    = 2'b01;
  localparam logic [1:0] MODE_2    = 2'b10;
  localparam logic [1:0] MODE_3    = 2'b11;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

  // "Next" cycles through the active modes only; HOME is left but never
  // re-entered this way.
  function automatic logic [1:0] mode_advance(input logic [1:0] mode);
    logic [1:0] nxt;
    case (mode)
      MODE_HOME: nxt = MODE_1;
      MODE_1:    nxt = MODE_2;
      MODE_2:    nxt = MODE_3;
      default:   nxt = MODE_1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mode_selector_if.sv
// Button / mode bundle of the mode selector.
//   btn_next_i, btn_home_i : raw asynchronous push-buttons, active-high
//   mode_o                 : registered mode word
//   mode_changed_o         : one-cycle strobe in the first cycle of a new mode
// slave  : the mode selector side
// master : the board / environment side
interface mode_selector_if;

  logic       btn_next_i;
  logic       btn_home_i;
  logic [1:0] mode_o;
  logic       mode_changed_o;

  modport slave (
    input  btn_next_i,
    input  btn_home_i,
    output mode_o,
    output mode_changed_o
  );

  modport master (
    output btn_next_i,
    output btn_home_i,
    input  mode_o,
    input  mode_changed_o
  );

endinterface

// File: rtl/mode_selector_button_debouncer.sv
// One push-button front end: 2-flop synchroniser, hold-time debouncer and
// rising-edge press detector.
//   clock_i  : system clock
//   reset_ni : asynchronous active-low reset, clears every flop
//   btn_i    : raw asynchronous button level
//   press_o  : one-cycle pulse in the cycle after the debounced level rises
module button_debouncer #(
  parameter  int DEBOUNCE_CYCLES = 1000000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             deb_p2;
  logic             deb_prev_p3;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_p0     <= 1'b0;
      sync_p1     <= 1'b0;
      deb_p2      <= 1'b0;
      deb_prev_p3 <= 1'b0;
      cnt         <= '0;
    end else begin
      // stage p0/p1: metastability synchroniser
      sync_p0 <= btn_i;
      sync_p1 <= sync_p0;

      // stage p2: new level accepted only after DEBOUNCE_CYCLES
      // consecutive disagreeing samples; any agreement restarts the count
      if (sync_p1 == deb_p2) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb_p2 <= sync_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // stage p3: history for edge detection
      deb_prev_p3 <= deb_p2;
    end
  end

  // Rising edges only: releases and long holds produce nothing.
  assign press_o = deb_p2 & ~deb_prev_p3;

endmodule

// File: rtl/mode_selector.sv
// Mode selector: debounces the "next" and "home" buttons and steps a small
// mode FSM whose state is the mode word itself.
//   clock_i  : system clock
//   reset_ni : asynchronous active-low reset (mode HOME, no strobe)
//   bus      : slave side of mode_selector_if
//              (btn_next_i, btn_home_i in; mode_o, mode_changed_o out)
module mode_selector
  import mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic           clock_i,
  input  logic           reset_ni,
  mode_selector_if.slave bus
);

  logic       press_next;
  logic       press_home;
  logic [1:0] mode_d;
  logic [1:0] mode_q;
  logic       changed_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .btn_i    (bus.btn_next_i),
    .press_o  (press_next)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_home (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .btn_i    (bus.btn_home_i),
    .press_o  (press_home)
  );

  // Home outranks next when both presses land in the same cycle.
  always_comb begin
    mode_d = mode_q;
    if (press_home) begin
      mode_d = MODE_HOME;
    end else if (press_next) begin
      mode_d = mode_advance(mode_q);
    end
  end

  // Strobe is registered alongside the mode so it coincides with the first
  // cycle of the new value; a home press while already HOME leaves it low.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mode_q    <= MODE_HOME;
      changed_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      changed_q <= (mode_d != mode_q);
    end
  end

  assign bus.mode_o         = mode_q;
  assign bus.mode_changed_o = changed_q;

endmodule
